dmem_arbiter: RTL

- Shares the single-port data memory between two requesters: the CPU load/store path (cpu_*) and an auxiliary master (aux_*, e.g. a boot loader or debug port).
- Arbitration is CPU-priority with an aux starvation limit and an aux lock for atomic read-modify-write sequences.
- Per-request handshake: req/gnt, then a registered read-data return.
- Range and alignment fault checks are done before the memory is touched. The block sits between the requesters and the data memory; memory-side ports connect 1:1 to its write_data_i/address_i/mem_write_i/mem_read_i/data_o.

---
 rtl/dmem_pkg.sv | 17 +
 rtl/dmem_addr_check.sv | 22 ++
 rtl/dmem_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM states,
// default memory base address and the aux wait-counter width.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CPU      = 2'd1,
        AUX      = 2'd2,
        AUX_LOCK = 2'd3
    } state_e;

    localparam logic [31:0] DMEM_BASE_ADDR = 32'h1001_0000;

    localparam int WAIT_CNT_W = 4;
    typedef logic [WAIT_CNT_W-1:0] wait_cnt_t;

endpackage

// File: rtl/dmem_addr_check.sv
// Combinational range/alignment check of a byte address against the
// data-memory window [BASE_ADDR, BASE_ADDR + 4*MEMORY_DEPTH).
module dmem_addr_check
    import dmem_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    MEMORY_DEPTH = 1024,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR    = DATA_WIDTH'(DMEM_BASE_ADDR)
) (
    input  logic [DATA_WIDTH-1:0] addr,
    output logic                  fault
);

    // One extra bit so a window ending at the top of the address space cannot wrap.
    localparam logic [DATA_WIDTH:0] LIMIT =
        {1'b0, BASE_ADDR} + (DATA_WIDTH+1)'(4 * MEMORY_DEPTH);

    assign fault = (addr < BASE_ADDR)
                || ({1'b0, addr} >= LIMIT)
                || (addr[1:0] != 2'b00);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter in front of the single-port data memory: CPU priority,
// bounded aux starvation, aux lock for atomic sequences, fault screening.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    MEMORY_DEPTH = 1024,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR    = DATA_WIDTH'(DMEM_BASE_ADDR),
    parameter int                    MAX_WAIT     = 4
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  cpu_req_i,
    input  logic                  cpu_we_i,
    input  logic [DATA_WIDTH-1:0] cpu_addr_i,
    input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
    output logic                  cpu_gnt_o,
    output logic                  cpu_rvalid_o,
    output logic [DATA_WIDTH-1:0] cpu_rdata_o,
    output logic                  cpu_fault_o,

    input  logic                  aux_req_i,
    input  logic                  aux_we_i,
    input  logic [DATA_WIDTH-1:0] aux_addr_i,
    input  logic [DATA_WIDTH-1:0] aux_wdata_i,
    input  logic                  aux_lock_i,
    output logic                  aux_gnt_o,
    output logic                  aux_rvalid_o,
    output logic [DATA_WIDTH-1:0] aux_rdata_o,
    output logic                  aux_fault_o,

    output logic [DATA_WIDTH-1:0] mem_address_o,
    output logic [DATA_WIDTH-1:0] mem_write_data_o,
    output logic                  mem_write_o,
    output logic                  mem_read_o,
    input  logic [DATA_WIDTH-1:0] mem_data_i,

    output state_e                dbg_state_o,
    output wait_cnt_t             dbg_wait_cnt_o
);

    // Handshake: a requester holds req/we/addr/wdata stable until gnt is seen
    // high in the same cycle; exactly one cycle after each gnt, rvalid pulses
    // with rdata/fault for that access. Dropping req before gnt has no effect.

    localparam wait_cnt_t WAIT_TOP = wait_cnt_t'(MAX_WAIT - 1);

    state_e    state, state_nxt;
    wait_cnt_t wait_cnt;

    logic                  cpu_win, aux_win, any_win, lock_stall;
    logic                  sel_we;
    logic [DATA_WIDTH-1:0] sel_addr, sel_wdata;
    logic                  addr_fault;

    assign lock_stall = (state == AUX_LOCK) && aux_lock_i;

    always_comb begin
        cpu_win = 1'b0;
        aux_win = 1'b0;
        if (!reset) begin
            cpu_win = 1'b0;
            aux_win = 1'b0;
        end else if (lock_stall) begin
            aux_win = aux_req_i;
        end else if (cpu_req_i && aux_req_i) begin
            aux_win = (wait_cnt == WAIT_TOP);
            cpu_win = (wait_cnt != WAIT_TOP);
        end else begin
            cpu_win = cpu_req_i;
            aux_win = aux_req_i;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        if (cpu_win)
            state_nxt = CPU;
        else if (aux_win)
            state_nxt = aux_lock_i ? AUX_LOCK : AUX;
        else if (lock_stall)
            state_nxt = AUX_LOCK;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Saturating count of cycles aux has been denied while requesting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            wait_cnt <= '0;
        else if (aux_win)
            wait_cnt <= '0;
        else if (aux_req_i && (wait_cnt != WAIT_TOP))
            wait_cnt <= wait_cnt + 1'b1;
    end

    assign any_win   = cpu_win || aux_win;
    assign sel_we    = aux_win ? aux_we_i    : cpu_we_i;
    assign sel_addr  = aux_win ? aux_addr_i  : cpu_addr_i;
    assign sel_wdata = aux_win ? aux_wdata_i : cpu_wdata_i;

    dmem_addr_check #(
        .DATA_WIDTH   (DATA_WIDTH),
        .MEMORY_DEPTH (MEMORY_DEPTH),
        .BASE_ADDR    (BASE_ADDR)
    ) u_addr_check (
        .addr  (sel_addr),
        .fault (addr_fault)
    );

    always_comb begin
        mem_address_o    = '0;
        mem_write_data_o = '0;
        mem_write_o      = 1'b0;
        mem_read_o       = 1'b0;
        if (any_win && !addr_fault) begin
            mem_address_o    = sel_addr;
            mem_write_data_o = sel_wdata;
            mem_write_o      = sel_we;
            mem_read_o       = !sel_we;
        end
    end

    // Responses: rdata is zero for writes and faults, otherwise the memory word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_rvalid_o <= 1'b0;
            cpu_fault_o  <= 1'b0;
            cpu_rdata_o  <= '0;
            aux_rvalid_o <= 1'b0;
            aux_fault_o  <= 1'b0;
            aux_rdata_o  <= '0;
        end else begin
            cpu_rvalid_o <= cpu_win;
            cpu_fault_o  <= cpu_win && addr_fault;
            aux_rvalid_o <= aux_win;
            aux_fault_o  <= aux_win && addr_fault;
            if (cpu_win)
                cpu_rdata_o <= (addr_fault || cpu_we_i) ? '0 : mem_data_i;
            if (aux_win)
                aux_rdata_o <= (addr_fault || aux_we_i) ? '0 : mem_data_i;
        end
    end

    assign cpu_gnt_o      = cpu_win;
    assign aux_gnt_o      = aux_win;
    assign dbg_state_o    = state;
    assign dbg_wait_cnt_o = wait_cnt;

endmodule
